// File: rtl/result_unloader.sv
// ---------------------------------------------------------------------------
// result_unloader
//
// Purpose:
//   Sits downstream of the RISCVCPU. When the CPU raises done, reads the
//   M x N2 result matrix out of data memory through a byte-wide synchronous
//   read port, reassembles big-endian 32-bit words and streams them on a
//   valid/ready interface, followed by two trailer words carrying the
//   latched clock_count and instr_cnt. Provides a synthesizable unload
//   path (e.g. towards a UART or host link).
//
// Ports:
//   CLOCK_50     in   system clock, all state on the rising edge
//   reset        in   asynchronous, active-high reset
//   done         in   CPU program-complete level; its rising edge starts
//   clock_count  in   CPU total cycle count (latched at start)
//   instr_cnt    in   CPU retired-instruction count (latched at start)
//   mem_rd_en    out  byte read strobe to data memory
//   mem_addr     out  byte address to data memory
//   mem_rdata    in   read byte, valid the cycle after mem_rd_en/mem_addr
//   out_data     out  streamed word
//   out_valid    out  out_data valid
//   out_ready    in   consumer accepts on out_valid && out_ready at an edge
//   out_last     out  marks the final word (instr_cnt trailer)
//   busy         out  unload in progress
//   finished     out  all words accepted; sticky until reset
// ---------------------------------------------------------------------------
module result_unloader #(
   parameter int M      = 3,
   parameter int N      = 4,
   parameter int N2     = 1,
   parameter int ADDR_W = 16
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              done,
   input  logic [15:0]       clock_count,
   input  logic [15:0]       instr_cnt,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              finished
);

   // Result matrix sits after matrix1 (M x N) and matrix2 (N x N2) words.
   localparam int BASE_I = M * N * 4 + N * N2 * 4;
   localparam int NWORDS = M * N2;
   localparam int W_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_I);
   localparam logic [W_W-1:0]    LAST_WORD = W_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      TRAIL_CC,
      TRAIL_IC,
      DONE
   } state_t;

   state_t          state;
   state_t          state_n;
   logic            done_d;
   logic [W_W-1:0]  w;
   // cnt 0..3 issue byte reads k=0..3; cnt 1..4 capture the previous read.
   logic [2:0]      cnt;
   logic [31:0]     word;
   logic [15:0]     cc_lat;
   logic [15:0]     ic_lat;
   logic            start;
   logic            last_word;
   logic [ADDR_W-1:0] word_off;

   assign start     = done & ~done_d;
   assign last_word = (w == LAST_WORD);
   assign word_off  = ADDR_W'({w, 2'b00});

   // State register.
   // NOTE: clocked state is assigned with <= so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and outputs.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      out_data  = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      finished  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = FETCH;
            end
         end

         FETCH: begin
            busy = 1'b1;
            if (cnt != 3'd4) begin
               mem_rd_en = 1'b1;
               mem_addr  = BASE + word_off + ADDR_W'(cnt);
            end else begin
               // Last byte lands this edge; the word is complete.
               state_n = HOLD;
            end
         end

         HOLD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = word;
            if (out_ready) begin
               state_n = last_word ? TRAIL_CC : FETCH;
            end
         end

         TRAIL_CC: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = {16'h0000, cc_lat};
            if (out_ready) begin
               state_n = TRAIL_IC;
            end
         end

         TRAIL_IC: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_data  = {16'h0000, ic_lat};
            if (out_ready) begin
               state_n = DONE;
            end
         end

         DONE: begin
            // Sticky until reset; later done edges are ignored.
            finished = 1'b1;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Datapath: done edge detector, word index, byte counter, assembly and
   // counter latches.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         done_d <= 1'b0;
         w      <= '0;
         cnt    <= '0;
         word   <= '0;
         cc_lat <= '0;
         ic_lat <= '0;
      end else begin
         done_d <= done;
         case (state)
            IDLE: begin
               if (start) begin
                  w      <= '0;
                  cnt    <= '0;
                  cc_lat <= clock_count;
                  ic_lat <= instr_cnt;
               end
            end

            FETCH: begin
               cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
               // Shift left so byte k=0 ends up in [31:24] (big-endian).
               if (cnt != 3'd0) begin
                  word <= {word[23:0], mem_rdata};
               end
            end

            HOLD: begin
               if (out_ready && !last_word) begin
                  w   <= w + W_W'(1);
                  cnt <= '0;
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_unloader.sv
// ---------------------------------------------------------------------------
// tb_result_unloader
//
// Self-checking bench for result_unloader. A default-parameter instance and
// an M=2,N=2,N2=2 instance each read from a byte-array memory model with a
// one-cycle read latency. Negedge monitors record issued addresses and
// accepted words; expected streams are built directly from the memory
// contents and the counter values applied at start.
// ---------------------------------------------------------------------------
module tb_result_unloader;

   typedef logic [7:0]  mem_t [0:255];
   typedef logic [31:0] wq_t [$];
   typedef bit          lq_t [$];
   typedef logic [15:0] aq_t [$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        done;
   logic        done2;
   logic [15:0] cc;
   logic [15:0] ic;

   // Default instance signals.
   logic        rd_en;
   logic [15:0] addr;
   logic [7:0]  rdata;
   logic [31:0] odata;
   logic        ovalid;
   logic        oready;
   logic        olast;
   logic        busy;
   logic        fin;

   // M=2, N=2, N2=2 instance signals.
   logic        rd_en2;
   logic [15:0] addr2;
   logic [7:0]  rdata2;
   logic [31:0] odata2;
   logic        ovalid2;
   logic        oready2;
   logic        olast2;
   logic        busy2;
   logic        fin2;

   result_unloader dut (
      .CLOCK_50(clk), .reset(reset), .done(done),
      .clock_count(cc), .instr_cnt(ic),
      .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
      .out_data(odata), .out_valid(ovalid), .out_ready(oready),
      .out_last(olast), .busy(busy), .finished(fin)
   );

   result_unloader #(.M(2), .N(2), .N2(2), .ADDR_W(16)) dut2 (
      .CLOCK_50(clk), .reset(reset), .done(done2),
      .clock_count(cc), .instr_cnt(ic),
      .mem_rd_en(rd_en2), .mem_addr(addr2), .mem_rdata(rdata2),
      .out_data(odata2), .out_valid(ovalid2), .out_ready(oready2),
      .out_last(olast2), .busy(busy2), .finished(fin2)
   );

   mem_t mem1;
   mem_t mem2;

   always @(posedge clk) begin
      if (rd_en)  rdata  <= mem1[addr[7:0]];
      if (rd_en2) rdata2 <= mem2[addr2[7:0]];
   end

   wq_t wq1, wq2;
   lq_t lq1, lq2;
   aq_t aq1, aq2;

   // Outputs are stable mid-cycle; what is seen here is what the next
   // rising edge acts on.
   always @(negedge clk) begin
      if (ovalid && oready) begin
         wq1.push_back(odata);
         lq1.push_back(olast);
      end
      if (rd_en) aq1.push_back(addr);
      if (ovalid2 && oready2) begin
         wq2.push_back(odata2);
         lq2.push_back(olast2);
      end
      if (rd_en2) aq2.push_back(addr2);
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_queues();
      wq1.delete(); lq1.delete(); aq1.delete();
      wq2.delete(); lq2.delete(); aq2.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_data"},  odata,  32'h0);
      check({tag, "_valid"}, ovalid, 32'h0);
      check({tag, "_last"},  olast,  32'h0);
      check({tag, "_busy"},  busy,   32'h0);
      check({tag, "_fin"},   fin,    32'h0);
      check({tag, "_rden"},  rd_en,  32'h0);
      check({tag, "_addr"},  addr,   32'h0);
   endtask

   // Reference: result word w is bytes base+4w..base+4w+3, most significant
   // first, followed by the two zero-extended counter trailers.
   task automatic check_stream(input string tag, input wq_t gw, input lq_t gl, input aq_t ga,
                               input mem_t m, input int base, input int nw,
                               input logic [15:0] c, input logic [15:0] i);
      logic [31:0] ew [$];
      logic [15:0] ea [$];
      for (int k = 0; k < nw; k++) begin
         ew.push_back({m[base+4*k], m[base+4*k+1], m[base+4*k+2], m[base+4*k+3]});
         for (int b = 0; b < 4; b++) ea.push_back(16'(base + 4*k + b));
      end
      ew.push_back({16'h0000, c});
      ew.push_back({16'h0000, i});
      check({tag, "_nwords"}, gw.size(), ew.size());
      for (int j = 0; j < ew.size(); j++) begin
         check($sformatf("%s_w%0d", tag, j), (j < gw.size()) ? gw[j] : 32'hx, ew[j]);
         check($sformatf("%s_last%0d", tag, j), (j < gl.size()) ? 32'(gl[j]) : 32'hx,
               32'(j == ew.size() - 1));
      end
      check({tag, "_naddr"}, ga.size(), ea.size());
      for (int j = 0; j < ea.size(); j++) begin
         check($sformatf("%s_a%0d", tag, j), (j < ga.size()) ? ga[j] : 16'hx, ea[j]);
      end
   endtask

   task automatic wait_valid1(input string tag, input int max);
      int n = 0;
      while (!ovalid && n < max) begin
         tick();
         n++;
      end
      check({tag, "_valid_seen"}, ovalid, 32'h1);
   endtask

   task automatic wait_fin1(input string tag, input int max, input bit rnd);
      int n = 0;
      while (!fin && n < max) begin
         if (rnd) oready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      oready = 1'b1;
      check({tag, "_finished"}, fin, 32'h1);
   endtask

   task automatic wait_fin2(input string tag, input int max);
      int n = 0;
      while (!fin2 && n < max) begin
         oready2 = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      oready2 = 1'b1;
      check({tag, "_finished"}, fin2, 32'h1);
   endtask

   task automatic randomize_mem1();
      for (int a = 0; a < 256; a++) mem1[a] = 8'($urandom);
   endtask

   initial begin
      int nw_saved;
      int na_saved;
      bit hit;
      logic [15:0] cc_exp;
      logic [15:0] ic_exp;

      reset   = 1'b1;
      done    = 1'b0;
      done2   = 1'b0;
      cc      = '0;
      ic      = '0;
      oready  = 1'b1;
      oready2 = 1'b1;
      for (int a = 0; a < 256; a++) begin
         mem1[a] = 8'h00;
         mem2[a] = 8'h00;
      end

      // Reset state.
      repeat (2) @(posedge clk);
      #2;
      check_idle_outputs("reset");
      reset = 1'b0;
      clear_queues();
      tick();

      // Nominal run with fixed bytes, plus counter latch at start.
      {mem1[64], mem1[65], mem1[66], mem1[67]} = 32'h0000001E;
      {mem1[68], mem1[69], mem1[70], mem1[71]} = 32'hFFFFFFF6;
      {mem1[72], mem1[73], mem1[74], mem1[75]} = 32'h00000100;
      cc   = 16'h0123;
      ic   = 16'h00C8;
      done = 1'b1;
      tick();                       // E0
      cc   = 16'hFFFF;              // must not reach the trailer
      done = 1'b0;
      check("e0_busy", busy, 32'h1);
      check("e0_rden", rd_en, 32'h1);
      check("e0_addr", addr, 32'd64);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("e0p%0d_valid", k), ovalid, 32'h0);
      end
      tick();                       // E0+5
      check("e0p5_valid", ovalid, 32'h1);
      check("e0p5_data", odata, 32'h0000001E);
      wait_fin1("nom", 200, 1'b0);
      check("nom_word0", wq1[0], 32'h0000001E);
      check("nom_word1", wq1[1], 32'hFFFFFFF6);
      check("nom_word2", wq1[2], 32'h00000100);
      check("nom_word3", wq1[3], 32'h00000123);
      check("nom_word4", wq1[4], 32'h000000C8);
      check_stream("nom", wq1, lq1, aq1, mem1, 64, 3, 16'h0123, 16'h00C8);
      check("nom_busy", busy, 32'h0);

      // Re-trigger after finished: level and fresh edges are ignored.
      nw_saved = wq1.size();
      na_saved = aq1.size();
      done = 1'b1; repeat (3) tick();
      done = 1'b0; repeat (2) tick();
      done = 1'b1; repeat (3) tick();
      done = 1'b0; tick();
      check("retrig_naddr", aq1.size(), na_saved);
      check("retrig_nwords", wq1.size(), nw_saved);
      check("retrig_fin", fin, 32'h1);
      check("retrig_busy", busy, 32'h0);

      // Backpressure on word 1 with random contents.
      reset = 1'b1;
      tick();
      clear_queues();
      reset = 1'b0;
      randomize_mem1();
      cc_exp = 16'($urandom);
      ic_exp = 16'($urandom);
      cc = cc_exp;
      ic = ic_exp;
      oready = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_valid1("bp_w0", 50);
      check("bp_w0_data", odata, {mem1[64], mem1[65], mem1[66], mem1[67]});
      oready = 1'b1;
      tick();
      oready = 1'b0;
      wait_valid1("bp_w1", 50);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_hold%0d_valid", k), ovalid, 32'h1);
         check($sformatf("bp_hold%0d_data", k), odata, {mem1[68], mem1[69], mem1[70], mem1[71]});
         check($sformatf("bp_hold%0d_rden", k), rd_en, 32'h0);
         tick();
      end
      wait_fin1("bp", 400, 1'b1);
      check_stream("bp", wq1, lq1, aq1, mem1, 64, 3, cc_exp, ic_exp);

      // Reset during FETCH of word 1, then done already high out of reset.
      reset = 1'b1;
      tick();
      clear_queues();
      reset = 1'b0;
      randomize_mem1();
      oready = 1'b1;
      done = 1'b1;
      tick();
      done = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
         if (rd_en && addr == 16'd68) hit = 1'b1;
         else tick();
      end
      check("mid_fetch_w1_seen", hit, 32'h1);
      reset = 1'b1;
      done  = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      tick();
      clear_queues();
      cc_exp = 16'($urandom);
      ic_exp = 16'($urandom);
      cc = cc_exp;
      ic = ic_exp;
      reset = 1'b0;
      tick();                       // first edge after release: start
      check("restart_busy", busy, 32'h1);
      check("restart_addr", addr, 32'd64);
      wait_fin1("restart", 400, 1'b1);
      done = 1'b0;
      check_stream("restart", wq1, lq1, aq1, mem1, 64, 3, cc_exp, ic_exp);

      // Other geometry: BASE=32, four result words.
      for (int a = 0; a < 256; a++) mem2[a] = 8'($urandom);
      cc_exp = 16'($urandom);
      ic_exp = 16'($urandom);
      cc = cc_exp;
      ic = ic_exp;
      done2 = 1'b1;
      tick();
      done2 = 1'b0;
      wait_fin2("param", 400);
      check_stream("param", wq2, lq2, aq2, mem2, 32, 4, cc_exp, ic_exp);
      check("param_dut1_quiet", aq1.size(), 32'd12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Sits directly downstream of RISCVCPU.
- When the CPU raises `done`, it reads the M×N2 result matrix out of data memory through a byte-wide synchronous read port and reassembles big-endian 32-bit words.
- Streams those words on a valid/ready interface, then appends two trailer words carrying clock_count and instr_cnt.
- Replaces testbench-side hierarchical peeking at data memory with a synthesizable unload path (e.g. to a UART/host).

Parameters:
- M, 3, rows in matrix1 (matches CPU parameter 1)
- N, 4, columns in matrix1 / rows in matrix2 (matches CPU parameter 2)
- N2, 1, columns in matrix2 (matches CPU parameter 3)
- ADDR_W, 16, data-memory byte-address width

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- done  in  1  CPU program-complete flag (level; rising edge starts unload)
- clock_count  in  16  CPU total cycle count
- instr_cnt  in  16  CPU retired-instruction count
- mem_rd_en  out  1  byte read strobe to data memory
- mem_addr  out  ADDR_W  byte address to data memory
- mem_rdata  in  8  read byte, valid the cycle after mem_rd_en/mem_addr
- out_data  out  32  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready at a clock edge
- out_last  out  1  marks final word (instr_cnt trailer)
- busy  out  1  unload in progress
- finished  out  1  all words accepted; sticky until reset

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; word index 0; byte counters 0; done-edge register 0.
- BASE = M*N*4 + N*N2*4 (64 at defaults). NWORDS = M*N2 (3 at defaults). Result word w is located at bytes BASE+4w .. BASE+4w+3.
- Internal done_d register; start = done & ~done_d, evaluated only in IDLE.
- States: IDLE, FETCH, HOLD, TRAIL_CC, TRAIL_IC, DONE.
- IDLE: on a clock edge E0 with start=1, go to FETCH with w=0 and latch clock_count/instr_cnt. busy=1 from E0.
- FETCH:
  - mem_rd_en=1 for exactly 4 cycles following E0 (or following the word's entry), with mem_addr = BASE+4w+k for k=0,1,2,3.
  - mem_rdata is captured at the 4 subsequent edges. Byte k=0 goes to out_data[31:24], k=3 to [7:0] (big-endian).
  - At the edge where byte 3 is captured (E0+5), enter HOLD with out_valid=1.
  - mem_rd_en=0 outside FETCH.
- HOLD:
  - out_data and out_valid are held stable while out_ready=0; no timeout.
  - On accept: if w<NWORDS-1, set w++ and re-enter FETCH. The next word's first address is driven in the cycle after accept, and out_valid=0 while fetching.
  - If w=NWORDS-1, go to TRAIL_CC.
- TRAIL_CC: out_valid=1, out_data={16'h0, latched clock_count}. Go to TRAIL_IC on accept.
- TRAIL_IC: out_valid=1, out_last=1, out_data={16'h0, latched instr_cnt}. Go to DONE on accept.
- DONE: busy=0, finished=1, out_valid=0. Further done edges are ignored until reset.
- done falling during an unload has no effect.
- A done pulse that is already high out of reset counts as a rising edge on the first edge after reset deassertion.
- Address arithmetic is in ADDR_W bits and wraps modulo 2^ADDR_W.
- reset mid-operation aborts immediately: IDLE, outputs 0, no partial word emitted.
- out_last is asserted only together with out_valid in TRAIL_IC.

Test Plan:
- Nominal: defaults, memory bytes 64..75 = 00 00 00 1E, FF FF FF F6, 00 00 01 00; clock_count=0x0123, instr_cnt=0x00C8; out_ready=1; pulse done → five words 0x0000001E, 0xFFFFFFF6, 0x00000100, 0x00000123, 0x000000C8; out_last only on the fifth; first out_valid at E0+5; finished=1 afterward.
- Address/timing: same run → mem_addr sequence 64,65,66,67 then 68..71 then 72..75, each with mem_rd_en=1; mem_rd_en=0 in HOLD/trailers; no other addresses issued.
- Backpressure: out_ready=0 for 10 cycles on word 1 → out_data stays 0xFFFFFFF6 with out_valid=1, no memory reads; stream resumes in order when out_ready=1.
- Counter latch: change clock_count to 0xFFFF after E0 → trailer still 0x00000123.
- Reset mid-unload: assert reset during FETCH of word 1 → all outputs 0 next instant; re-pulsing done restarts from address 64 and emits word 0 again.
- Re-trigger/level: hold done high after finished, then toggle it → no new reads; finished stays 1. Parameter check M=2,N=2,N2=2 → BASE=32, 4 result words at 32..47.
